// File: rtl/inception_conv11_sched_pkg.sv
// Shared definitions for the Inception 1x1 branch scheduler and its sibling conv blocks.
package inception_conv11_sched_pkg;

   localparam int unsigned NUM_BR_DEF    = 4;
   localparam int unsigned BIT_WIDTH_DEF = 6;
   localparam int unsigned LAT_DEF       = 2;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned BR_ID_W = id_width(NUM_BR_DEF);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/inception_conv11_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr and returns the next pointer.
module inception_conv11_sched_rr_arbiter #(
   parameter int unsigned N    = 4,
   parameter int unsigned ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic            valid,
   output logic [ID_W-1:0] idx,
   output logic [ID_W-1:0] next_ptr
);

   int unsigned     cand;
   logic [ID_W-1:0] cand_id;

   always_comb begin
      gnt     = '0;
      valid   = 1'b0;
      idx     = '0;
      cand    = 0;
      cand_id = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand    = (32'(ptr) + k) % N;
         cand_id = ID_W'(cand);
         if (!valid && req[cand_id]) begin
            valid        = 1'b1;
            gnt[cand_id] = 1'b1;
            idx          = cand_id;
         end
      end
      next_ptr = ptr;
      if (valid) begin
         next_ptr = (32'(idx) == N - 1) ? '0 : idx + ID_W'(1);
      end
   end

endmodule

// File: rtl/inception_conv11_sched.sv
// Time-multiplexes one shared 1x1 conv unit among the Inception branches, tagging each issue.
module inception_conv11_sched
   import inception_conv11_sched_pkg::*;
#(
   parameter int unsigned  NUM_BR    = NUM_BR_DEF,
   parameter int unsigned  BIT_WIDTH = BIT_WIDTH_DEF,
   parameter int unsigned  LAT       = LAT_DEF,
   parameter int unsigned  FRAME_LEN = 16,
   localparam int unsigned ID_W      = id_width(NUM_BR)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [NUM_BR-1:0]           req,
   input  logic [NUM_BR*BIT_WIDTH-1:0] br_data,
   input  logic [NUM_BR*BIT_WIDTH-1:0] br_kernel,
   output logic [NUM_BR-1:0]           gnt,
   output logic [BIT_WIDTH-1:0]        conv_in_data,
   output logic [BIT_WIDTH-1:0]        conv_kernel,
   input  logic [BIT_WIDTH-1:0]        conv_out_data,
   output logic                        out_valid,
   output logic [ID_W-1:0]             out_branch,
   output logic [BIT_WIDTH-1:0]        out_data,
   output logic                        done
);

   localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

   sched_state_e      state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q [NUM_BR];
   logic [CNT_W-1:0]  cnt_d [NUM_BR];
   logic [LAT-1:0]    tag_vld_q, tag_vld_d;
   logic [ID_W-1:0]   tag_id_q [LAT];
   logic [ID_W-1:0]   tag_id_d [LAT];

   logic [NUM_BR-1:0] eligible, arb_gnt;
   logic              arb_valid, issue, all_issued, pending;
   logic [ID_W-1:0]   arb_idx, arb_next_ptr;

   always_comb begin
      for (int i = 0; i < NUM_BR; i++) begin
         eligible[i] = req[i] && (cnt_q[i] < CNT_W'(FRAME_LEN));
      end
   end

   inception_conv11_sched_rr_arbiter #(
      .N    (NUM_BR),
      .ID_W (ID_W)
   ) u_arb (
      .req      (eligible),
      .ptr      (ptr_q),
      .gnt      (arb_gnt),
      .valid    (arb_valid),
      .idx      (arb_idx),
      .next_ptr (arb_next_ptr)
   );

   // Reset masks every output in the cycle it is asserted.
   assign issue = rst && (state_q == StRun) && en && arb_valid;
   assign gnt   = issue ? arb_gnt : '0;

   always_comb begin
      conv_in_data = '0;
      conv_kernel  = '0;
      for (int i = 0; i < NUM_BR; i++) begin
         if (gnt[i]) begin
            conv_in_data = br_data[i*BIT_WIDTH +: BIT_WIDTH];
            conv_kernel  = br_kernel[i*BIT_WIDTH +: BIT_WIDTH];
         end
      end
   end

   // Results still behind the head mean the drain is not finished.
   always_comb begin
      pending      = 1'b0;
      tag_vld_d[0] = issue;
      tag_id_d[0]  = arb_idx;
      for (int i = 1; i < LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end
      for (int i = 0; i < LAT - 1; i++) begin
         pending = pending | tag_vld_q[i];
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      all_issued = 1'b1;
      if (issue) begin
         cnt_d[arb_idx] = cnt_q[arb_idx] + CNT_W'(1);
         ptr_d          = arb_next_ptr;
      end
      for (int i = 0; i < NUM_BR; i++) begin
         all_issued = all_issued && (cnt_d[i] == CNT_W'(FRAME_LEN));
      end
      unique case (state_q)
         StIdle:  if (en) state_d = StRun;
         StRun:   if (all_issued) state_d = StDrain;
         StDrain: if (!pending) state_d = StDone;
         StDone: begin
            cnt_d   = '{default: '0};
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         cnt_q     <= '{default: '0};
         tag_vld_q <= '0;
         tag_id_q  <= '{default: '0};
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         tag_vld_q <= tag_vld_d;
         tag_id_q  <= tag_id_d;
      end
   end

   assign out_valid  = rst && tag_vld_q[LAT-1];
   assign out_branch = out_valid ? tag_id_q[LAT-1] : '0;
   assign out_data   = out_valid ? conv_out_data : '0;
   assign done       = rst && (state_q == StDone);

endmodule
